// File: rtl/req_sync_bridge_pkg.sv
// Shared constants and helpers for clocked bridges that take bundled-data
// tokens out of the asynchronous pipeline.
package req_sync_bridge_pkg;

  // Default width of the bundled data word.
  localparam int DATA_W_DEFAULT = 32;

  // Fewer than two flops gives no real metastability protection.
  localparam int SYNC_STAGES_MIN = 2;

  // Occupancy counters need one extra bit so that "full" (== depth) fits.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : req_sync_bridge_pkg

// File: rtl/req_sync_bridge_if.sv
// Handshake bundle of the request bridge: 2-phase request/ack with bundled
// data on the asynchronous side, valid/ready plus occupancy on the clocked side.
interface req_sync_bridge_if
  import req_sync_bridge_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 4
) ();

  logic                          in_req;
  logic [DATA_W-1:0]             in_data;
  logic                          in_ack;
  logic                          out_valid;
  logic [DATA_W-1:0]             out_data;
  logic                          out_ready;
  logic [count_width(DEPTH)-1:0] count;

  // Bridge side.
  modport slave (
    input  in_req, in_data, out_ready,
    output in_ack, out_valid, out_data, count
  );

  // Environment side: upstream pipeline plus downstream consumer.
  modport master (
    output in_req, in_data, out_ready,
    input  in_ack, out_valid, out_data, count
  );

endinterface : req_sync_bridge_if

// File: rtl/req_sync_bridge_sync_chain.sv
// Generic N-stage flop chain for bringing a level into the clk domain.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] stage_q;

  // Shift the sampled level one flop further each edge; reset clears all stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule : sync_chain

// File: rtl/req_sync_bridge.sv
// Captures 2-phase bundled-data tokens into a small first-word-fall-through
// FIFO and returns a 2-phase acknowledge only once a token has been stored,
// so the upstream pipeline stalls by itself while the FIFO is full.
module req_sync_bridge
  import req_sync_bridge_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  req_sync_bridge_if.slave bus
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = count_width(DEPTH);
  // Never build a chain shorter than the safe minimum.
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic          valid_q, valid_d;

  logic req_s;
  logic pending;
  logic push;
  logic pop;

  // Only the request level is synchronized; in_data is held stable by the
  // bundling constraint until our ack toggles, so it is sampled directly.
  sync_chain #(
    .STAGES (STAGES)
  ) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.in_req),
    .q_o (req_s)
  );

  // Token handshake and next-state of pointers, occupancy and ack phase.
  always_comb begin
    pending  = req_s ^ ack_q;
    pop      = valid_q && bus.out_ready;
    // A pop in the same edge frees the slot the push needs, so full+pop still accepts.
    push     = pending && ((count_q < CW'(DEPTH)) || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ack_d    = ack_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      ack_d    = ~ack_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);
  end

  // Control state; reset realigns the ack phase with the (also reset) upstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
    end
  end

  // Storage is not reset; stale words are never visible because valid is cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ack    = ack_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = mem[rd_ptr_q];
  assign bus.count     = count_q;

endmodule : req_sync_bridge
